hazard_unit: RTL and testbench
==============================

# hazard_unit

Parametrised hazard-control unit for the five-stage RISC-V pipeline, driving stall, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. It generalises load-use detection to a configurable load-to-use penalty, qualifies operands by actual use and x0, handles taken-branch flushes and data-memory wait states, and keeps a saturating stall-cycle counter for performance monitoring. It sits in the core top level beside the forwarding unit and replaces the single-case load-use detector.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width
- LOAD_STALL_CYCLES, 1, bubbles needed between a load in EX and a dependent instruction in ID; legal range 1..7
- PERF_CNT_W, 16, width of the stall-cycle counter

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- if_id_rs1  in  REG_ADDR_W  rs1 of the instruction in ID
- if_id_rs2  in  REG_ADDR_W  rs2 of the instruction in ID
- if_id_rs1_used  in  1  ID instruction reads rs1
- if_id_rs2_used  in  1  ID instruction reads rs2
- id_ex_rd  in  REG_ADDR_W  rd of the instruction in EX
- id_ex_memread  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- dmem_busy  in  1  data memory cannot complete the MEM-stage access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_bubble  out  1  load NOP into ID/EX
- ex_mem_stall  out  1  hold EX/MEM and MEM/WB
- stall_cycles  out  PERF_CNT_W  saturating count of cycles with pc_stall high

## Operation
- Hazard condition: hit = id_ex_memread && id_ex_rd != 0 && ((if_id_rs1_used && rs1 == id_ex_rd) || (if_id_rs2_used && rs2 == id_ex_rd)).
- Registered state: IDLE, LOAD_STALL; 3-bit remaining-bubble counter rem.
- IDLE: hit -> assert pc_stall, if_id_stall, id_ex_bubble this cycle. If LOAD_STALL_CYCLES > 1, go to LOAD_STALL with rem = LOAD_STALL_CYCLES-1; otherwise stay in IDLE.
- LOAD_STALL: assert pc_stall, if_id_stall, id_ex_bubble every cycle; rem decrements; rem == 1 at the clock edge -> IDLE. hit is ignored here because the load has left EX.
- ex_branch_taken (highest priority after dmem_busy): if_id_flush = 1 and id_ex_bubble = 1; pc_stall and if_id_stall = 0; any load-use stall is cancelled (state -> IDLE, rem -> 0) because the dependent instruction is squashed.
- dmem_busy (highest priority): pc_stall, if_id_stall and ex_mem_stall = 1; id_ex_bubble and if_id_flush = 0; state and rem frozen; branch and hit evaluation suppressed. Load-use stalls resume when busy drops.
- stall_cycles increments on every edge where pc_stall = 1 and saturates at all-ones. It is cleared only by reset.
- Outputs are combinational functions of the registered state and the current inputs. No output depends on the previous cycle's inputs except through state.

## Timing
- Reset: state IDLE, rem 0, stall_cycles 0. With reset high, all control outputs are 0 regardless of inputs.
- Detection latency is 0 cycles: the stall appears in the same cycle hit is true.
- Total stall length for one load-use is exactly LOAD_STALL_CYCLES cycles, plus any dmem_busy cycles inserted in between.
- Branch and hit in the same cycle: the branch wins. There is no stall, and there is a flush.
- Branch in a LOAD_STALL cycle: the flush applies and the FSM returns to IDLE on that edge.
- dmem_busy and branch in the same cycle: freeze only. The branch is acted on in the first non-busy cycle because EX is held.
- Reset asserted mid-LOAD_STALL: IDLE on the next edge. stall_cycles is cleared.
- Back-to-back loads: the second hit is evaluated only in IDLE after the first stall completes.

## Structure
- Package hazard_pkg: state enum (IDLE, LOAD_STALL) and a typedef for the control-output struct {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall}.
- Elaboration check: LOAD_STALL_CYCLES must be in 1..7.
- One sub-module, perf_sat_counter (parametrised width, enable, synchronous clear), instantiated for stall_cycles. The FSM and priority logic stay in hazard_unit.

## Test plan
- LOAD_STALL_CYCLES=1: lw x5 in EX, ID reads x5 via rs2 -> pc_stall, if_id_stall and id_ex_bubble high for exactly 1 cycle; stall_cycles = 1.
- LOAD_STALL_CYCLES=3, same dependency -> stall high for 3 consecutive cycles, then low; stall_cycles = 3; a dependency on rd = x0, or on an unused rs2 with a matching number, gives no stall.
- LOAD_STALL_CYCLES=3: branch taken in the 2nd stall cycle -> if_id_flush = 1 that cycle, stall ends, state IDLE next cycle.
- dmem_busy held 4 cycles during a LOAD_STALL with rem = 2 -> ex_mem_stall high for 4 cycles, no bubbles; then 2 remaining bubble cycles; stall_cycles incremented 6 times.
- PERF_CNT_W=4: force 20 stall cycles -> stall_cycles saturates at 15.
- Reset pulsed mid-stall -> all outputs 0 during reset; IDLE and stall_cycles = 0 afterwards.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard-control unit.
// Combinational control decode; no latency of its own.
// Backpressure comes from dmem_busy, which freezes all hazard state.
package hazard_pkg;

  typedef enum logic {
    IDLE       = 1'b0,
    LOAD_STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_stall;
  } hz_ctrl_t;

  localparam int REM_W          = 3;
  localparam int MAX_LOAD_STALL = 7;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter with synchronous clear.
// Count visible one cycle after the enabling edge.
// No backpressure; holds at all-ones once saturated.
module perf_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use / branch / dmem-wait hazard control for the 5-stage pipeline.
// Zero-cycle detection: controls are combinational on state and inputs.
// dmem_busy freezes the pipeline and all hazard state until it drops.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int PERF_CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_rs1_used,
  input  logic                  if_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_memread,
  input  logic                  ex_branch_taken,
  input  logic                  dmem_busy,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_stall,
  output logic [PERF_CNT_W-1:0] stall_cycles
);

  generate
    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > MAX_LOAD_STALL) begin : g_bad_param
      $error("hazard_unit: LOAD_STALL_CYCLES must be in 1..7");
    end
  endgenerate

  localparam logic [REM_W-1:0] LOAD_REM = REM_W'(LOAD_STALL_CYCLES - 1);

  hz_state_e        state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  hz_ctrl_t         ctrl;
  logic             hit;

  // Only operands the ID instruction really reads can create a dependency; x0 never does.
  assign hit = id_ex_memread && (id_ex_rd != '0) &&
               ((if_id_rs1_used && (if_id_rs1 == id_ex_rd)) ||
                (if_id_rs2_used && (if_id_rs2 == id_ex_rd)));

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    rem_d   = rem_q;
    if (reset) begin
      ctrl = '0;
    end else if (dmem_busy) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.ex_mem_stall = 1'b1;
    end else if (ex_branch_taken) begin
      // The dependent instruction is squashed, so any pending load-use stall is moot.
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
      state_d           = IDLE;
      rem_d             = '0;
    end else if (state_q == LOAD_STALL) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
      rem_d             = rem_q - 1'b1;
      if (rem_q == REM_W'(1)) begin
        state_d = IDLE;
      end
    end else if (hit) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = LOAD_STALL;
        rem_d   = LOAD_REM;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign ex_mem_stall = ctrl.ex_mem_stall;

  perf_sat_counter #(
    .WIDTH(PERF_CNT_W)
  ) u_stall_cnt (
    .clock(clock),
    .clear(reset),
    .en   (ctrl.pc_stall),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Drives three hazard_unit configurations with shared directed stimulus and
// checks every cycle against a behavioural model plus literal expectations.
module tb_hazard_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, rd;
  logic       rs1_used, rs2_used, memread, branch, busy;
  logic       chk_en = 1'b0;

  // Index 0: LSC=1/W16, 1: LSC=3/W16, 2: LSC=7/W4
  logic        pc_s [3], ifid_s [3], flush [3], bubble [3], exmem [3];
  logic [15:0] sc_a, sc_b;
  logic [3:0]  sc_c;
  logic [15:0] sc [3];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  hazard_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .PERF_CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used), .id_ex_rd(rd),
    .id_ex_memread(memread), .ex_branch_taken(branch), .dmem_busy(busy),
    .pc_stall(pc_s[0]), .if_id_stall(ifid_s[0]), .if_id_flush(flush[0]),
    .id_ex_bubble(bubble[0]), .ex_mem_stall(exmem[0]), .stall_cycles(sc_a));

  hazard_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .PERF_CNT_W(16)) dut_b (
    .clock(clock), .reset(reset), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used), .id_ex_rd(rd),
    .id_ex_memread(memread), .ex_branch_taken(branch), .dmem_busy(busy),
    .pc_stall(pc_s[1]), .if_id_stall(ifid_s[1]), .if_id_flush(flush[1]),
    .id_ex_bubble(bubble[1]), .ex_mem_stall(exmem[1]), .stall_cycles(sc_b));

  hazard_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(7), .PERF_CNT_W(4)) dut_c (
    .clock(clock), .reset(reset), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used), .id_ex_rd(rd),
    .id_ex_memread(memread), .ex_branch_taken(branch), .dmem_busy(busy),
    .pc_stall(pc_s[2]), .if_id_stall(ifid_s[2]), .if_id_flush(flush[2]),
    .id_ex_bubble(bubble[2]), .ex_mem_stall(exmem[2]), .stall_cycles(sc_c));

  assign sc[0] = sc_a;
  assign sc[1] = sc_b;
  assign sc[2] = {12'b0, sc_c};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bubbles still owed to a pending load-use, and stall-cycle total.
  int lsc  [3] = '{1, 3, 7};
  int cmax [3] = '{65535, 65535, 15};
  int owed [3] = '{0, 0, 0};
  int cnt  [3] = '{0, 0, 0};

  always @(negedge clock) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        bit hz, e_pc, e_flush, e_bub, e_mem;
        hz = memread && (rd != 0) &&
             ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
        e_pc = 0; e_flush = 0; e_bub = 0; e_mem = 0;
        if (reset) begin
          owed[k] = 0;
        end else if (busy) begin
          e_pc = 1; e_mem = 1;
        end else if (branch) begin
          e_flush = 1; e_bub = 1; owed[k] = 0;
        end else if (owed[k] > 0) begin
          e_pc = 1; e_bub = 1; owed[k] = owed[k] - 1;
        end else if (hz) begin
          e_pc = 1; e_bub = 1; owed[k] = lsc[k] - 1;
        end
        chk($sformatf("ctl[%0d]", k),
            {27'b0, pc_s[k], ifid_s[k], flush[k], bubble[k], exmem[k]},
            {27'b0, e_pc, e_pc, e_flush, e_bub, e_mem});
        chk($sformatf("stall_cycles[%0d]", k), {16'b0, sc[k]}, cnt[k]);
        if (reset) cnt[k] = 0;
        else if (e_pc && cnt[k] < cmax[k]) cnt[k] = cnt[k] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic peek();
    @(negedge clock);
    #1;
  endtask

  task automatic idle();
    rs1 = 5'd1; rs2 = 5'd2; rd = 5'd9; rs1_used = 1; rs2_used = 1;
    memread = 0; branch = 0; busy = 0;
  endtask

  task automatic set_hit();
    rs1 = 5'd3; rs1_used = 1; rs2 = 5'd5; rs2_used = 1; rd = 5'd5; memread = 1;
    branch = 0; busy = 0;
  endtask

  initial begin
    int na, nb, nc;
    idle();
    reset = 1;
    set_hit();
    branch = 1;
    tick();
    chk_en = 1;
    peek();
    chk("reset_pc_stall_a", pc_s[0], 1'b0);
    chk("reset_flush_b", flush[1], 1'b0);
    tick();
    reset = 0;
    idle();
    tick();

    // Single load-use on rs2
    set_hit();
    peek();
    chk("detect_same_cycle", pc_s[0], 1'b1);
    na = 0; nb = 0; nc = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin peek(); end
      na += pc_s[0]; nb += pc_s[1]; nc += pc_s[2];
      tick();
      idle();
    end
    chk("stall_len_lsc1", na, 1);
    chk("stall_len_lsc3", nb, 3);
    chk("stall_len_lsc7", nc, 7);
    peek();
    chk("sc_a_after_t1", sc_a, 16'd1);
    chk("sc_b_after_t1", sc_b, 16'd3);
    chk("sc_c_after_t1", sc_c, 4'd7);
    tick();

    // rd = x0 and unused-operand matches never stall
    memread = 1; rd = 5'd0; rs1 = 5'd0; rs1_used = 1;
    peek();
    chk("no_stall_x0", pc_s[1], 1'b0);
    tick();
    rd = 5'd5; rs2 = 5'd5; rs2_used = 0; rs1 = 5'd3;
    peek();
    chk("no_stall_unused_rs2", pc_s[1], 1'b0);
    tick();
    idle();
    tick();

    // Branch in the second stall cycle cancels the stall
    set_hit();
    tick();
    idle();
    branch = 1;
    peek();
    chk("branch_flush_b", flush[1], 1'b1);
    chk("branch_no_stall_b", pc_s[1], 1'b0);
    chk("branch_flush_c", flush[2], 1'b1);
    tick();
    idle();
    peek();
    chk("after_branch_idle_b", pc_s[1], 1'b0);
    chk("after_branch_idle_c", pc_s[2], 1'b0);
    tick();

    // dmem_busy for 4 cycles while B has 2 bubbles left
    set_hit();
    tick();
    idle();
    busy = 1;
    for (int i = 0; i < 4; i++) begin
      peek();
      chk("busy_exmem_b", exmem[1], 1'b1);
      chk("busy_no_bubble_b", bubble[1], 1'b0);
      tick();
    end
    busy = 0;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      peek();
      nb += bubble[1];
      tick();
    end
    chk("resumed_bubbles_b", nb, 2);
    peek();
    chk("sc_b_after_busy", sc_b, 16'd11);
    chk("sc_a_after_busy", sc_a, 16'd7);
    chk("sc_c_saturated_1", sc_c, 4'd15);
    tick();

    // Long busy window drives the 4-bit counter firmly into saturation
    busy = 1;
    for (int i = 0; i < 20; i++) tick();
    busy = 0;
    peek();
    chk("sc_c_saturated_2", sc_c, 4'd15);
    chk("sc_a_after_sat", sc_a, 16'd27);
    tick();

    // Reset in the middle of a load-use stall
    set_hit();
    tick();
    reset = 1;
    peek();
    chk("reset_mid_pc_b", pc_s[1], 1'b0);
    chk("reset_mid_bubble_b", bubble[1], 1'b0);
    tick();
    reset = 0;
    idle();
    peek();
    chk("post_reset_idle_b", pc_s[1], 1'b0);
    chk("post_reset_sc_b", sc_b, 16'd0);
    chk("post_reset_sc_c", sc_c, 4'd0);
    tick();
    tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
